// File: rtl/spi_reg_bank_sync_if.sv
// -----------------------------------------------------------------------------
// spi_reg_bank_sync_if
// MCU-side SPI pin bundle for the clock-domain register bank.
//   master : MCU / bench side   (drives spi_clk, spi_cs, spi_special, spi_mosi)
//   slave  : register bank side (drives spi_miso)
// -----------------------------------------------------------------------------
interface spi_reg_bank_sync_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_special;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_cs, output spi_special,
                  output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_cs, input spi_special,
                  input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_reg_bank_sync.sv
// -----------------------------------------------------------------------------
// spi_reg_bank_sync
// SPI register bank running entirely in the system clock domain. The SPI pins
// are oversampled, frames of {addr[7:0], clear[W-1:0], set[W-1:0]} are decoded
// and per-bit set/clear/toggle updates are applied to NREGS W-bit registers.
// The addressed register is shifted back on MISO during the data phase.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   spi         : SPI pin bundle (slave modport)
//   regs_out    : flattened register contents, register i at [i*W +: W]
//   wr_strobe   : one-cycle pulse when a commit or soft reset changes state
//   wr_addr     : address of the last committed frame
//   frame_err   : one-cycle pulse on a selected frame with a wrong bit count
// -----------------------------------------------------------------------------
module spi_reg_bank_sync #(
  parameter int                   W             = 4,
  parameter int                   NREGS         = 13,
  parameter int                   BASE_ADDR     = 7,
  parameter int                   SOFT_RST_ADDR = 6,
  parameter logic [NREGS*W-1:0]   RESET_VAL     = {(NREGS*W){1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_reg_bank_sync_if.slave      spi,
  output logic [NREGS*W-1:0]      regs_out,
  output logic                    wr_strobe,
  output logic [7:0]              wr_addr,
  output logic                    frame_err
);

  localparam int F   = 8 + 2*W;
  localparam int DW  = 2*W;
  localparam int SHW = (DW > 8) ? DW : 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  // Set/clear/toggle/hold per bit: s&~c sets, ~s&c clears, s&c toggles.
  function automatic logic [W-1:0] apply_update(input logic [W-1:0] old_v,
                                                input logic [W-1:0] s_v,
                                                input logic [W-1:0] c_v);
    return ((old_v | s_v) & ~c_v) | (s_v & c_v & ~old_v);
  endfunction

  // Synchroniser stages: [0] first FF, [1] second FF, [2] edge-detect history.
  logic [2:0]     sck_sync_r, cs_sync_r;
  logic [1:0]     sel_sync_r, mosi_sync_r;
  logic           sck_rise_r, sck_fall_r, cs_rise_r, cs_fall_r;
  logic           mosi_d_r, sel_d_r, cs_d_r;

  state_t         state_r;
  logic [7:0]     bit_cnt_r, bit_cnt_nx_s;
  logic [SHW-1:0] shift_r, shift_nx_s;
  logic [7:0]     addr_r;
  logic [DW-1:0]  rb_r;
  logic           miso_r;
  logic [W-1:0]   regs_r [NREGS];
  logic [W-1:0]   new_s  [NREGS];
  logic [W-1:0]   rd_val_s;
  logic           change_s;
  logic           wr_strobe_r, frame_err_r;
  logic [7:0]     wr_addr_r;

  // Pin synchronisers plus registered edge pulses aligned with sampled data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_r  <= 3'b000;
      cs_sync_r   <= 3'b000;
      sel_sync_r  <= 2'b00;
      mosi_sync_r <= 2'b00;
      sck_rise_r  <= 1'b0;
      sck_fall_r  <= 1'b0;
      cs_rise_r   <= 1'b0;
      cs_fall_r   <= 1'b0;
      mosi_d_r    <= 1'b0;
      sel_d_r     <= 1'b0;
      cs_d_r      <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], spi.spi_clk};
      cs_sync_r   <= {cs_sync_r[1:0], spi.spi_cs};
      sel_sync_r  <= {sel_sync_r[0], spi.spi_special};
      mosi_sync_r <= {mosi_sync_r[0], spi.spi_mosi};
      sck_rise_r  <= sck_sync_r[1] & ~sck_sync_r[2];
      sck_fall_r  <= ~sck_sync_r[1] & sck_sync_r[2];
      cs_rise_r   <= cs_sync_r[1] & ~cs_sync_r[2];
      cs_fall_r   <= ~cs_sync_r[1] & cs_sync_r[2];
      mosi_d_r    <= mosi_sync_r[1];
      sel_d_r     <= sel_sync_r[1];
      cs_d_r      <= cs_sync_r[1];
    end
  end

  // Bit shifted in this cycle is folded in before the frame-end check, so a
  // coincident spi_clk rise and spi_cs rise counts the bit first.
  always_comb begin
    bit_cnt_nx_s = bit_cnt_r;
    shift_nx_s   = shift_r;
    if (sck_rise_r && (state_r != IDLE)) begin
      bit_cnt_nx_s = (bit_cnt_r == 8'd255) ? 8'd255 : bit_cnt_r + 8'd1;
      shift_nx_s   = {shift_r[SHW-2:0], mosi_d_r};
    end else begin
      bit_cnt_nx_s = bit_cnt_r;
    end
  end

  // Readback lookup for the address completing this cycle, and commit values.
  always_comb begin
    rd_val_s = {W{1'b0}};
    change_s = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      rd_val_s = (shift_nx_s[7:0] == 8'(BASE_ADDR + i)) ? regs_r[i] : rd_val_s;
      new_s[i] = (addr_r == 8'(BASE_ADDR + i)) ?
                 apply_update(regs_r[i], shift_nx_s[W-1:0], shift_nx_s[DW-1:W]) :
                 regs_r[i];
      change_s = change_s | (new_s[i] != regs_r[i]);
    end
  end

  // Frame FSM, register file, MISO shifter and output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 8'd0;
      shift_r     <= {SHW{1'b0}};
      addr_r      <= 8'd0;
      rb_r        <= {DW{1'b0}};
      miso_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      wr_addr_r   <= 8'd0;
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= RESET_VAL[i*W +: W];
      end
    end else begin
      wr_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      bit_cnt_r   <= bit_cnt_nx_s;
      shift_r     <= shift_nx_s;

      // MISO only drives readback while selected and in the data phase.
      if (cs_d_r || (state_r != DATA)) begin
        miso_r <= 1'b0;
      end else if (sck_fall_r) begin
        miso_r <= rb_r[DW-1];
        rb_r   <= {rb_r[DW-2:0], 1'b0};
      end

      case (state_r)
        IDLE: begin
          if (cs_fall_r && !sel_d_r) begin
            state_r   <= ADDR;
            bit_cnt_r <= 8'd0;
            shift_r   <= {SHW{1'b0}};
          end
        end
        ADDR: begin
          if (cs_rise_r) begin
            frame_err_r <= 1'b1;
            state_r     <= IDLE;
          end else if (bit_cnt_nx_s == 8'd8) begin
            addr_r  <= shift_nx_s[7:0];
            rb_r    <= {rd_val_s, {W{1'b0}}};
            state_r <= DATA;
          end
        end
        DATA: begin
          if (cs_rise_r) begin
            if (bit_cnt_nx_s == 8'(F)) begin
              if (addr_r == 8'(SOFT_RST_ADDR)) begin
                for (int i = 0; i < NREGS; i++) begin
                  regs_r[i] <= RESET_VAL[i*W +: W];
                end
                wr_strobe_r <= 1'b1;
                wr_addr_r   <= 8'(SOFT_RST_ADDR);
              end else if (change_s) begin
                for (int i = 0; i < NREGS; i++) begin
                  regs_r[i] <= new_s[i];
                end
                wr_strobe_r <= 1'b1;
                wr_addr_r   <= addr_r;
              end
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[g*W +: W] = regs_r[g];
  end

  assign spi.spi_miso = miso_r;
  assign wr_strobe    = wr_strobe_r;
  assign wr_addr      = wr_addr_r;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_spi_reg_bank_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank_sync
// Directed bench for spi_reg_bank_sync (W=4, NREGS=13, BASE_ADDR=7,
// SOFT_RST_ADDR=6, RESET_VAL=0). SPI pins move on clk negedges with a
// half-period of HALF clk cycles; MISO is captured just before each rise.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank_sync;

  localparam int HALF = 8;

  logic        clk;
  logic        rst_n;
  logic [51:0] regs_out;
  logic        wr_strobe;
  logic [7:0]  wr_addr;
  logic        frame_err;

  int checks;
  int errors;

  logic [31:0] rb;
  logic        st_pre, st_at, st_post, er_pre, er_at, er_post;
  logic [51:0] regs_pre, regs_at;
  logic [7:0]  wa_at;

  spi_reg_bank_sync_if spi_if ();

  spi_reg_bank_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_if.slave),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_frame(input logic special);
    spi_if.spi_special = special;
    spi_if.spi_cs      = 1'b0;
    rb = 32'd0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi_if.spi_mosi = b;
    repeat (HALF) @(negedge clk);
    rb = {rb[30:0], spi_if.spi_miso};
    spi_if.spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_if.spi_clk = 1'b0;
  endtask

  // Raise spi_cs on a negedge and sample outputs after the 3rd/4th/5th posedge.
  task automatic finish_frame();
    repeat (HALF) @(negedge clk);
    spi_if.spi_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 st_pre = wr_strobe; er_pre = frame_err; regs_pre = regs_out;
    @(posedge clk);
    #1 st_at = wr_strobe; er_at = frame_err; regs_at = regs_out; wa_at = wr_addr;
    @(posedge clk);
    #1 st_post = wr_strobe; er_post = frame_err;
    @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] word, input int nbits, input logic special);
    start_frame(special);
    for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
    finish_frame();
  endtask

  task automatic test_reset();
    checks++; if (regs_out !== 52'h0) begin errors++; $display("FAIL reset_regs: got %h expected %h", regs_out, 52'h0); end
    checks++; if (spi_if.spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_if.spi_miso); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_set();
    spi_xfer(32'h0703, 16, 1'b0);
    checks++; if (regs_pre !== 52'h0) begin errors++; $display("FAIL set_latency_pre: got %h expected %h", regs_pre, 52'h0); end
    checks++; if (regs_at !== 52'h3) begin errors++; $display("FAIL set_reg0: got %h expected %h", regs_at, 52'h3); end
    checks++; if ({st_pre, st_at, st_post} !== 3'b010) begin errors++; $display("FAIL set_strobe: got %b expected 010", {st_pre, st_at, st_post}); end
    checks++; if (wa_at !== 8'h07) begin errors++; $display("FAIL set_wr_addr: got %h expected 07", wa_at); end
    checks++; if (er_at !== 1'b0) begin errors++; $display("FAIL set_frame_err: got %b expected 0", er_at); end
  endtask

  task automatic test_mix();
    spi_xfer(32'h0715, 16, 1'b0);
    checks++; if (regs_at !== 52'h6) begin errors++; $display("FAIL mix_reg0: got %h expected %h", regs_at, 52'h6); end
    checks++; if ({st_pre, st_at, st_post} !== 3'b010) begin errors++; $display("FAIL mix_strobe: got %b expected 010", {st_pre, st_at, st_post}); end
  endtask

  task automatic test_readback();
    spi_xfer(32'h0700, 16, 1'b0);
    checks++; if (rb[7:0] !== 8'h60) begin errors++; $display("FAIL readback_data: got %h expected 60", rb[7:0]); end
    checks++; if (rb[15:8] !== 8'h00) begin errors++; $display("FAIL readback_addr_phase: got %h expected 00", rb[15:8]); end
    checks++; if (regs_at !== 52'h6) begin errors++; $display("FAIL readback_reg0: got %h expected %h", regs_at, 52'h6); end
    checks++; if ({st_pre, st_at, st_post} !== 3'b000) begin errors++; $display("FAIL readback_strobe: got %b expected 000", {st_pre, st_at, st_post}); end
    checks++; if (wa_at !== 8'h07) begin errors++; $display("FAIL readback_wr_addr: got %h expected 07", wa_at); end
  endtask

  task automatic test_bad_length();
    spi_xfer(32'h08F, 12, 1'b0);
    checks++; if ({er_pre, er_at, er_post} !== 3'b010) begin errors++; $display("FAIL short_err: got %b expected 010", {er_pre, er_at, er_post}); end
    checks++; if (regs_at !== 52'h6) begin errors++; $display("FAIL short_regs: got %h expected %h", regs_at, 52'h6); end
    checks++; if (st_at !== 1'b0) begin errors++; $display("FAIL short_strobe: got %b expected 0", st_at); end
    spi_xfer(32'h0813F, 20, 1'b0);
    checks++; if ({er_pre, er_at, er_post} !== 3'b010) begin errors++; $display("FAIL long_err: got %b expected 010", {er_pre, er_at, er_post}); end
    checks++; if (regs_at !== 52'h6) begin errors++; $display("FAIL long_regs: got %h expected %h", regs_at, 52'h6); end
  endtask

  task automatic test_unmapped();
    spi_xfer(32'h140F, 16, 1'b0);
    checks++; if (regs_at !== 52'h6) begin errors++; $display("FAIL unmapped_regs: got %h expected %h", regs_at, 52'h6); end
    checks++; if ({st_at, er_at} !== 2'b00) begin errors++; $display("FAIL unmapped_pulses: got %b expected 00", {st_at, er_at}); end
  endtask

  task automatic test_soft_reset();
    spi_xfer(32'h080F, 16, 1'b0);
    spi_xfer(32'h130A, 16, 1'b0);
    checks++; if (regs_at !== 52'hA_0000_0000_00F6) begin errors++; $display("FAIL soft_setup: got %h expected %h", regs_at, 52'hA_0000_0000_00F6); end
    checks++; if (wa_at !== 8'h13) begin errors++; $display("FAIL last_reg_wr_addr: got %h expected 13", wa_at); end
    spi_xfer(32'h06AA, 16, 1'b0);
    checks++; if (regs_at !== 52'h0) begin errors++; $display("FAIL soft_regs: got %h expected %h", regs_at, 52'h0); end
    checks++; if ({st_pre, st_at, st_post} !== 3'b010) begin errors++; $display("FAIL soft_strobe: got %b expected 010", {st_pre, st_at, st_post}); end
    checks++; if (wa_at !== 8'h06) begin errors++; $display("FAIL soft_wr_addr: got %h expected 06", wa_at); end
    spi_xfer(32'h0703, 16, 1'b1);
    spi_if.spi_special = 1'b0;
    checks++; if (regs_at !== 52'h0) begin errors++; $display("FAIL special_regs: got %h expected %h", regs_at, 52'h0); end
    checks++; if (rb[15:0] !== 16'h0000) begin errors++; $display("FAIL special_miso: got %h expected 0000", rb[15:0]); end
    checks++; if ({st_at, er_at} !== 2'b00) begin errors++; $display("FAIL special_pulses: got %b expected 00", {st_at, er_at}); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    spi_xfer(32'h0703, 16, 1'b0);
    checks++; if (regs_at !== 52'h3) begin errors++; $display("FAIL midrst_setup: got %h expected %h", regs_at, 52'h3); end
    w = 16'h0705;
    start_frame(1'b0);
    for (int i = 15; i >= 11; i--) send_bit(w[i]);
    rst_n = 1'b0;
    #1;
    checks++; if (regs_out !== 52'h0) begin errors++; $display("FAIL midrst_regs: got %h expected %h", regs_out, 52'h0); end
    checks++; if (spi_if.spi_miso !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b expected 0", spi_if.spi_miso); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 10; i >= 0; i--) send_bit(w[i]);
    finish_frame();
    checks++; if ({st_pre, st_at, st_post, er_pre, er_at, er_post} !== 6'b000000) begin errors++; $display("FAIL midrst_pulses: got %b expected 000000", {st_pre, st_at, st_post, er_pre, er_at, er_post}); end
    checks++; if (regs_at !== 52'h0) begin errors++; $display("FAIL midrst_no_commit: got %h expected %h", regs_at, 52'h0); end
  endtask

  task automatic test_back_to_back();
    spi_xfer(32'h0705, 16, 1'b0);
    checks++; if (regs_at !== 52'h5) begin errors++; $display("FAIL b2b_first: got %h expected %h", regs_at, 52'h5); end
    spi_xfer(32'h0802, 16, 1'b0);
    checks++; if (regs_at !== 52'h25) begin errors++; $display("FAIL b2b_second: got %h expected %h", regs_at, 52'h25); end
    checks++; if ({st_at, wa_at} !== {1'b1, 8'h08}) begin errors++; $display("FAIL b2b_strobe_addr: got %b/%h expected 1/08", st_at, wa_at); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    spi_if.spi_clk = 1'b0;
    spi_if.spi_cs = 1'b1;
    spi_if.spi_special = 1'b0;
    spi_if.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    test_set();
    test_mix();
    test_readback();
    test_bad_length();
    test_unmapped();
    test_soft_reset();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank_sync.md
# spi_reg_bank_sync

Clock-domain SPI register bank that replaces the SPI-clocked register bank. It oversamples the MCU SPI pins in the system clock domain and decodes frames of one address byte plus 2×W data bits. It applies per-bit set/clear/toggle updates to NREGS W-bit control registers and returns the addressed register's current value on MISO during the same frame. It sits between the MCU SPI pins (when the special select is asserted) and the board control outputs (LEDs, rails, DAC, clamps, relays).

## Interface
- W, 4, register width; frame data field is 2×W bits (low W = set, high W = clear)
- NREGS, 13, number of registers
- BASE_ADDR, 7, address of register 0; register i lives at BASE_ADDR+i
- SOFT_RST_ADDR, 6, address that reloads all registers with RESET_VAL; must lie outside BASE_ADDR..BASE_ADDR+NREGS-1
- RESET_VAL, 0, NREGS×W-bit flattened reset image; register i = bits [i×W +: W]
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- spi_clk  in  1  SPI clock, mode 0, asynchronous to clk, frequency ≤ clk/8
- spi_cs  in  1  chip select, active low
- spi_special  in  1  register-bank select, active low
- spi_mosi  in  1  serial data in, MSB first
- spi_miso  out  1  serial data out, registered in clk domain
- regs_out  out  NREGS×W  flattened register contents
- wr_strobe  out  1  one-cycle pulse when any register changes by commit or soft reset
- wr_addr  out  8  address of the last committed frame; valid while wr_strobe is high
- frame_err  out  1  one-cycle pulse on a selected frame with wrong bit count

## Operation
- Synchronisation: spi_clk, spi_cs, spi_special and spi_mosi each pass through a 2-FF synchroniser. Edges are detected from the 2nd and 3rd stages. spi_mosi is taken from the 2nd stage at the detected spi_clk rise.
- Frame length F = 8 + 2W.
- State machine IDLE → ADDR → DATA → IDLE.
  - IDLE: wait for a synced spi_cs fall. If synced spi_special is low at that moment, go to ADDR with bitcnt=0. Otherwise stay in IDLE and ignore traffic until spi_cs rises. spi_special is sampled only at frame start.
  - ADDR: shift 8 bits. On the 8th rise, latch the address. Load the readback shift register with {reg[addr-BASE_ADDR], W'b0} if mapped, else all zeros. Go to DATA.
  - DATA: shift bits and count up to 255 (saturating). Stay until spi_cs rises.
  - On a synced spi_cs rise in ADDR or DATA:
    - If bitcnt == F: commit, then IDLE.
    - Otherwise: pulse frame_err, no register change, then IDLE.
- Commit rule, with s = data[W-1:0] and c = data[2W-1:W], applied per bit:
  - s=1, c=0: set.
  - s=0, c=1: clear.
  - s=1, c=1: toggle.
  - s=0, c=0: hold.
- Data 0 is a pure read: it is a no-op write with no wr_strobe.
- Mapped address with a non-zero change: update the register, pulse wr_strobe, and set wr_addr to the address.
- Unmapped address: no change, no strobe, no error.
- SOFT_RST_ADDR with bitcnt == F: all registers take RESET_VAL, wr_strobe pulses, and wr_addr = SOFT_RST_ADDR. The data field is ignored.
- MISO:
  - It is 0 in IDLE, during ADDR, and whenever synced spi_cs is high.
  - In DATA, spi_miso presents the readback MSB first. It advances on each synced spi_clk fall, starting at the fall after the 8th rise.
  - After 2W bits it outputs 0.
  - Tristating and muxing are external.

## Timing
- Reset (rst_n low), asynchronous:
  - Outputs: regs_out = RESET_VAL; spi_miso = 0; wr_strobe = 0; wr_addr = 0; frame_err = 0.
  - Internal: state = IDLE; synchroniser and shift registers = 0.
  - Reset released mid-frame: the block stays in IDLE until the next spi_cs fall. The partial frame is discarded with no frame_err.
- Commit latency: regs_out, wr_strobe and wr_addr update on the clk edge 4 cycles after the pin-level spi_cs rise (2 synchroniser cycles, 1 edge-detect cycle, 1 commit cycle). frame_err has the same latency.
- MISO latency: spi_miso changes 4 clk cycles after the pin-level spi_clk fall. It is stable at the next spi_clk rise given the spi_clk ≤ clk/8 constraint.
- Back-to-back frames: a new spi_cs fall may be accepted 1 clk after commit. The spi_cs high time must be ≥ 4 clk.
- Simultaneous synced spi_cs rise and spi_clk rise: the bit is counted first, then the frame-end check runs.

## Test plan
- Set: W=4, after reset with RESET_VAL=0, frame 0x07,0x03 → 4 clk after spi_cs rises, reg0=0x3, wr_strobe pulses once, wr_addr=0x07.
- Per-bit mix: with reg0=0x3, frame 0x07,0x15 (s=0x5, c=0x1) → bit0 toggles, bit2 sets, reg0=0x6.
- Readback and no-op: with reg0=0x6, frame 0x07,0x00 → spi_miso bits during the data phase are 0,1,1,0,0,0,0,0; reg0 unchanged; no wr_strobe.
- Short frame: 12-bit frame 0x08,0xF → frame_err single pulse; regs_out unchanged. Over-length 20-bit frame → frame_err pulse.
- Soft reset: set regs to non-zero values, then frame 0x06,0xAA → all regs equal RESET_VAL, wr_strobe pulses, wr_addr=0x06. A frame sent with spi_special high is ignored and spi_miso stays 0.
- Reset mid-frame: assert rst_n low after 5 bits of a frame → regs_out=RESET_VAL immediately. The remaining bits until spi_cs rises cause no commit and no frame_err.
